// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - sequencer that streams one k_len job into systolic_array and hands back its result
// i_arr_cycles carries the array's cycles_count so it can be captured at compute_done.
module systolic_feed_ctrl #(
  parameter int ROWS        = 64,
  parameter int COLS        = 64,
  parameter int IP_WIDTH    = 8,
  parameter int K_MAX       = 128,
  parameter int ADDR_W      = $clog2(K_MAX),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [ADDR_W:0]          i_k_len,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  input  logic [31:0]              i_arr_cycles,
  output logic [31:0]              o_cyc_cnt,
  output logic                     o_mem_rd_en,
  output logic [ADDR_W-1:0]        o_mem_rd_addr,
  input  logic [ROWS*IP_WIDTH-1:0] i_mem_in_data,
  input  logic [COLS*IP_WIDTH-1:0] i_mem_wt_data,
  output logic                     o_arr_en,
  output logic                     o_arr_clr,
  output logic [ROWS*IP_WIDTH-1:0] o_arr_input,
  output logic [COLS*IP_WIDTH-1:0] o_arr_weight,
  input  logic                     i_arr_done
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0]   K_MAX_L = (ADDR_W + 1)'(K_MAX);
  localparam logic [ADDR_W:0]   K_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_RESULT} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_err, w_err;
  logic                r_res_valid, w_res_valid;
  logic [31:0]         r_cyc_cnt, w_cyc_cnt;
  logic                r_rd_en, w_rd_en;
  logic [ADDR_W-1:0]   r_rd_addr, w_rd_addr;
  logic [ADDR_W-1:0]   r_k_last, w_k_last;
  logic                r_arr_en, w_arr_en;
  logic                r_arr_clr, w_arr_clr;
  logic [WD_W-1:0]     r_wd, w_wd;
  logic                w_k_ok;
  logic [ADDR_W:0]     w_k_m1;

  assign w_k_ok = (i_k_len != '0) && (i_k_len <= K_MAX_L);
  assign w_k_m1 = i_k_len - K_ONE;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_cyc_cnt   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_k_last    <= '0;
      r_arr_en    <= 1'b0;
      r_arr_clr   <= 1'b0;
      r_wd        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_res_valid <= w_res_valid;
      r_cyc_cnt   <= w_cyc_cnt;
      r_rd_en     <= w_rd_en;
      r_rd_addr   <= w_rd_addr;
      r_k_last    <= w_k_last;
      r_arr_en    <= w_arr_en;
      r_arr_clr   <= w_arr_clr;
      r_wd        <= w_wd;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_err       = r_err;
    w_res_valid = r_res_valid;
    w_cyc_cnt   = r_cyc_cnt;
    w_rd_en     = r_rd_en;
    w_rd_addr   = r_rd_addr;
    w_k_last    = r_k_last;
    w_wd        = r_wd;
    // Array beats trail the memory read by one cycle; clr marks the token-0 beat.
    w_arr_en    = r_rd_en;
    w_arr_clr   = r_rd_en && (r_rd_addr == '0);

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_k_ok) begin
            w_k_last    = w_k_m1[ADDR_W-1:0];
            w_err       = 1'b0;
            w_rd_en     = 1'b1;
            w_rd_addr   = '0;
            w_state_nxt = S_FEED;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (r_rd_addr == r_k_last) begin
          w_rd_en     = 1'b0;
          w_wd        = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_addr = r_rd_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (i_arr_done && !r_arr_en) begin
          w_cyc_cnt   = i_arr_cycles;
          w_res_valid = 1'b1;
          w_state_nxt = S_RESULT;
        end else if (r_wd == WD_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wd = r_wd + WD_W'(1);
        end
      end
      S_RESULT: begin
        if (r_res_valid && i_res_ready) begin
          w_res_valid = 1'b0;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort outranks completion, result handoff and the watchdog.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_rd_en     = 1'b0;
      w_arr_en    = 1'b0;
      w_arr_clr   = 1'b0;
      w_res_valid = 1'b0;
      w_done      = 1'b0;
      w_err       = r_err;
      w_cyc_cnt   = r_cyc_cnt;
    end

    w_busy = (w_state_nxt != S_IDLE);
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_res_valid   = r_res_valid;
  assign o_cyc_cnt     = r_cyc_cnt;
  assign o_mem_rd_en   = r_rd_en;
  assign o_mem_rd_addr = r_rd_addr;
  assign o_arr_en      = r_arr_en;
  assign o_arr_clr     = r_arr_clr;
  assign o_arr_input   = r_arr_en ? i_mem_in_data : '0;
  assign o_arr_weight  = r_arr_en ? i_mem_wt_data : '0;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - directed bench for systolic_feed_ctrl with a 1-cycle vector memory model
module tb_systolic_feed_ctrl;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int IPW  = 8;
  localparam int KMAX = 128;
  localparam int AW   = 7;
  localparam int TO   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [AW:0]          k_len = '0;
  logic                 abort = 1'b0;
  logic                 busy, done, err, res_valid;
  logic                 res_ready = 1'b0;
  logic [31:0]          arr_cycles = '0;
  logic [31:0]          cyc_cnt;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_rd_addr;
  logic [ROWS*IPW-1:0]  mem_in_data = '0;
  logic [COLS*IPW-1:0]  mem_wt_data = '0;
  logic                 arr_en, arr_clr;
  logic [ROWS*IPW-1:0]  arr_input;
  logic [COLS*IPW-1:0]  arr_weight;
  logic                 arr_done = 1'b0;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;

  systolic_feed_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .IP_WIDTH(IPW), .K_MAX(KMAX), .ADDR_W(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_k_len(k_len), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_err(err), .o_res_valid(res_valid),
    .i_res_ready(res_ready), .i_arr_cycles(arr_cycles), .o_cyc_cnt(cyc_cnt),
    .o_mem_rd_en(mem_rd_en), .o_mem_rd_addr(mem_rd_addr),
    .i_mem_in_data(mem_in_data), .i_mem_wt_data(mem_wt_data),
    .o_arr_en(arr_en), .o_arr_clr(arr_clr), .o_arr_input(arr_input),
    .o_arr_weight(arr_weight), .i_arr_done(arr_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fin(input int i);
    return 16'(i * 7 + 257);
  endfunction

  function automatic logic [15:0] fwt(input int i);
    return 16'((i * 13) ^ 32'h0000_A5C3);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_in_data <= fin(int'(mem_rd_addr));
      mem_wt_data <= fwt(int'(mem_rd_addr));
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a start, then check every cycle from the first read through the first DRAIN cycle.
  task automatic run_feed(input int k, input int done_at, input int start_at);
    start = 1'b1;
    k_len = (AW + 1)'(k);
    tick;
    start = 1'b0;
    for (int c = 1; c <= k + 1; c++) begin
      arr_done = (c == done_at);
      start    = (c == start_at);
      chk("rd_en", 32'(mem_rd_en), 32'(c <= k));
      if (c <= k) chk("rd_addr", 32'(mem_rd_addr), 32'(c - 1));
      chk("arr_en", 32'(arr_en), 32'(c >= 2));
      chk("arr_clr", 32'(arr_clr), 32'(c == 2));
      chk("arr_input", 32'(arr_input), (c >= 2) ? 32'(fin(c - 2)) : 32'd0);
      chk("arr_weight", 32'(arr_weight), (c >= 2) ? 32'(fwt(c - 2)) : 32'd0);
      chk("busy_feed", 32'(busy), 32'd1);
      tick;
    end
    arr_done = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_arr_en", 32'(arr_en), 32'd0);
    chk("rst_arr_clr", 32'(arr_clr), 32'd0);
    chk("rst_cyc_cnt", cyc_cnt, 32'd0);
    tick;

    // k_len=4; arr_done at cycle 5 (last beat still in flight) must be ignored
    run_feed(4, 5, 0);
    chk("k4_no_early_result", 32'(res_valid), 32'd0);
    chk("k4_arr_en_low", 32'(arr_en), 32'd0);
    repeat (14) tick;
    chk("k4_busy_c20", 32'(busy), 32'd1);
    arr_done   = 1'b1;
    arr_cycles = 32'd17;
    res_ready  = 1'b1;
    tick;
    arr_done = 1'b0;
    chk("k4_res_valid", 32'(res_valid), 32'd1);
    chk("k4_cyc_cnt", cyc_cnt, 32'd17);
    chk("k4_done_early", 32'(done), 32'd0);
    tick;
    chk("k4_done", 32'(done), 32'd1);
    chk("k4_res_valid_clr", 32'(res_valid), 32'd0);
    chk("k4_busy_fall", 32'(busy), 32'd0);
    tick;
    res_ready = 1'b0;
    chk("k4_done_pulse", 32'(done), 32'd0);
    chk("k4_done_cnt", 32'(done_cnt), 32'd1);

    // illegal lengths
    start = 1'b1;
    k_len = '0;
    tick;
    start = 1'b0;
    chk("k0_err", 32'(err), 32'd1);
    chk("k0_busy", 32'(busy), 32'd0);
    chk("k0_rd_en", 32'(mem_rd_en), 32'd0);
    tick;
    chk("k0_busy_hold", 32'(busy), 32'd0);
    start = 1'b1;
    k_len = (AW + 1)'(129);
    tick;
    start = 1'b0;
    chk("k129_err", 32'(err), 32'd1);
    chk("k129_busy", 32'(busy), 32'd0);
    chk("k129_rd_en", 32'(mem_rd_en), 32'd0);
    chk("illegal_done_cnt", 32'(done_cnt), 32'd1);

    // k_len=1 clears err; result held while consumer stalls
    run_feed(1, 0, 0);
    chk("k1_err_cleared", 32'(err), 32'd0);
    arr_done   = 1'b1;
    arr_cycles = 32'd33;
    tick;
    arr_done = 1'b0;
    chk("k1_cyc_cnt", cyc_cnt, 32'd33);
    for (int i = 0; i < 5; i++) begin
      chk("k1_res_valid_hold", 32'(res_valid), 32'd1);
      chk("k1_no_done", 32'(done), 32'd0);
      tick;
    end
    res_ready = 1'b1;
    chk("k1_res_valid_last", 32'(res_valid), 32'd1);
    tick;
    res_ready = 1'b0;
    chk("k1_done", 32'(done), 32'd1);
    chk("k1_res_valid_clr", 32'(res_valid), 32'd0);
    tick;
    chk("k1_done_cnt", 32'(done_cnt), 32'd2);

    // watchdog: DRAIN entered at cycle 3, IDLE at cycle 19; arr_done in FEED ignored
    run_feed(2, 1, 0);
    for (int c = 4; c <= 18; c++) begin
      chk("to_busy", 32'(busy), 32'd1);
      chk("to_err_low", 32'(err), 32'd0);
      tick;
    end
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_err", 32'(err), 32'd1);
    chk("to_cyc_cnt_kept", cyc_cnt, 32'd33);
    tick;
    tick;
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_done_cnt", 32'(done_cnt), 32'd2);

    // abort at 3rd FEED cycle of k_len=8, with a stray start in FEED
    start = 1'b1;
    k_len = (AW + 1)'(8);
    tick;
    start = 1'b0;
    chk("ab_addr0", 32'(mem_rd_addr), 32'd0);
    chk("ab_err_cleared", 32'(err), 32'd0);
    tick;
    start = 1'b1;
    chk("ab_addr1", 32'(mem_rd_addr), 32'd1);
    tick;
    start = 1'b0;
    abort = 1'b1;
    chk("ab_addr2", 32'(mem_rd_addr), 32'd2);
    chk("ab_rd_en_c3", 32'(mem_rd_en), 32'd1);
    tick;
    abort = 1'b0;
    chk("ab_rd_en", 32'(mem_rd_en), 32'd0);
    chk("ab_arr_en", 32'(arr_en), 32'd0);
    chk("ab_arr_clr", 32'(arr_clr), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_err", 32'(err), 32'd0);
    tick;
    chk("ab_not_queued", 32'(busy), 32'd0);
    chk("ab_done_cnt", 32'(done_cnt), 32'd2);

    // full-length job
    run_feed(KMAX, 0, 0);
    arr_done   = 1'b1;
    arr_cycles = 32'd12345;
    res_ready  = 1'b1;
    tick;
    arr_done = 1'b0;
    chk("full_res_valid", 32'(res_valid), 32'd1);
    chk("full_cyc_cnt", cyc_cnt, 32'd12345);
    tick;
    chk("full_done", 32'(done), 32'd1);
    chk("full_busy", 32'(busy), 32'd0);
    tick;
    res_ready = 1'b0;
    chk("full_done_cnt", 32'(done_cnt), 32'd3);

    // reset mid-job
    start = 1'b1;
    k_len = (AW + 1)'(4);
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mid_rst_arr_en", 32'(arr_en), 32'd0);
    chk("mid_rst_cyc_cnt", cyc_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
